// File: rtl/oled_spi_tx.sv
// oled_spi_tx: power-up sequencer and SPI mode-0 byte transmitter for an OLED panel.
// After reset it holds the panel reset low, waits for the panel to settle, and then
// accepts bytes on a valid/ready handshake. Each byte is shifted out MSB first,
// with data/command select and chip select framing the byte.
// Ports:
//   clock, reset         system clock; asynchronous active-high reset
//   tx_valid/tx_ready    byte handshake (tx_ready asserted only when idle)
//   tx_data, tx_dc       byte to send and its data(1)/command(0) flag
//   oled_clk, oled_mosi  SPI clock and data
//   oled_dc, oled_cs_n   data/command select and active-low chip select
//   oled_rst_n           active-low panel reset
//   init_done            power-up sequence complete
module oled_spi_tx #(
    parameter int unsigned CLK_DIV         = 2,
    parameter int unsigned RST_LOW_CYCLES  = 16,
    parameter int unsigned RST_WAIT_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_dc,
    output logic       tx_ready,
    output logic       oled_clk,
    output logic       oled_mosi,
    output logic       oled_dc,
    output logic       oled_cs_n,
    output logic       oled_rst_n,
    output logic       init_done
);

    localparam int unsigned PWR_MAX = (RST_LOW_CYCLES > RST_WAIT_CYCLES) ? RST_LOW_CYCLES
                                                                         : RST_WAIT_CYCLES;
    localparam int unsigned PW      = $clog2(PWR_MAX + 1);
    localparam int unsigned DW      = 8;
    localparam int unsigned BW      = 3;

    typedef enum logic [2:0] {
        RST_LOW,
        RST_WAIT,
        IDLE,
        SHIFT,
        END
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   pwr_q, pwr_d;
    logic [DW-1:0]   div_q, div_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [6:0]      shreg_q, shreg_d;   // bits still to send after the one on mosi
    logic            ready_d, sclk_d, mosi_d, dc_d, cs_n_d, rst_n_d, done_d;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d = state_q;
        pwr_d   = pwr_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        ready_d = tx_ready;
        sclk_d  = oled_clk;
        mosi_d  = oled_mosi;
        dc_d    = oled_dc;
        cs_n_d  = oled_cs_n;
        rst_n_d = oled_rst_n;
        done_d  = init_done;

        case (state_q)
            RST_LOW: begin
                if (pwr_q == PW'(RST_LOW_CYCLES - 1)) begin
                    state_d = RST_WAIT;
                    pwr_d   = '0;
                    rst_n_d = 1'b1;
                end else begin
                    pwr_d = pwr_q + PW'(1);
                end
            end
            RST_WAIT: begin
                if (pwr_q == PW'(RST_WAIT_CYCLES - 1)) begin
                    state_d = IDLE;
                    pwr_d   = '0;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                end else begin
                    pwr_d = pwr_q + PW'(1);
                end
            end
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    state_d = SHIFT;
                    shreg_d = tx_data[6:0];
                    mosi_d  = tx_data[7];
                    dc_d    = tx_dc;
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b0;
                    ready_d = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                end
            end
            SHIFT: begin
                if (div_q == DW'(CLK_DIV - 1)) begin
                    div_d = '0;
                    if (!oled_clk) begin
                        sclk_d = 1'b1;
                    end else begin
                        // Falling edge: advance to the next bit, or finish after bit 0.
                        sclk_d = 1'b0;
                        if (bit_q == BW'(7)) begin
                            state_d = END;
                        end else begin
                            bit_d   = bit_q + BW'(1);
                            mosi_d  = shreg_q[6];
                            shreg_d = {shreg_q[5:0], 1'b0};
                        end
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            END: begin
                state_d = IDLE;
                cs_n_d  = 1'b1;
                ready_d = 1'b1;
                mosi_d  = 1'b0;
            end
            default: begin
                state_d = RST_LOW;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= RST_LOW;
            pwr_q      <= '0;
            div_q      <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            tx_ready   <= 1'b0;
            oled_clk   <= 1'b0;
            oled_mosi  <= 1'b0;
            oled_dc    <= 1'b0;
            oled_cs_n  <= 1'b1;
            oled_rst_n <= 1'b0;
            init_done  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pwr_q      <= pwr_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            tx_ready   <= ready_d;
            oled_clk   <= sclk_d;
            oled_mosi  <= mosi_d;
            oled_dc    <= dc_d;
            oled_cs_n  <= cs_n_d;
            oled_rst_n <= rst_n_d;
            init_done  <= done_d;
        end
    end

endmodule
